passcode_scramble_register: RTL and testbench

Programming-side counterpart of the passcode comparator. It collects a new 4-digit passcode keyed in one BCD digit at a time while programming mode is active. On commit it scrambles the code into the stored digit order and holds it as `stored_code`, the input of the comparison stage. It also owns the power-on default code.

---
 rtl/passcode_scramble_register.sv | 195 +++++++++++++++++++
 tb/tb_passcode_scramble_register.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_scramble_register.sv
// passcode_scramble_register
//
// Programming side of the passcode lock. While prog_en_i is high it collects
// a new 4-digit BCD passcode one digit at a time. On commit it scrambles the
// code into the stored digit order {d2,d1,d3,d0} and holds it on
// stored_code_o for the comparison stage. Reset loads the scrambled
// DEFAULT_CODE.
//
// Optional feature: define CONFIRM_ENTRY_EN for double-entry confirmation.
// The code must be keyed twice, and both entries must match before the
// write happens.
//
// Handshake: digit_valid_i, commit_i and cancel_i are single-cycle strobes
// sampled on every rising edge. There is no back-pressure, so an event that
// arrives in a state that cannot use it is rejected with an entry_error_o
// pulse or is dropped silently.
//
// Ports:
//   clk_i          clock; all logic runs on the rising edge
//   reset_i        synchronous, active-high reset
//   prog_en_i      programming mode; dropping it during entry aborts
//   digit_in_i     BCD digit; 0-9 are legal
//   digit_valid_i  strobe qualifying digit_in_i
//   commit_i       strobe: store the buffered code
//   cancel_i       strobe: abort the entry
//   stored_code_o  scrambled stored code {d2,d1,d3,d0}
//   code_written_o one-cycle pulse when stored_code_o is updated
//   entry_error_o  one-cycle pulse on a rejected event, timeout or mismatch
//   busy_o         high while an entry or write is in progress
//   digit_count_o  digits buffered in the current entry (0-4)
//   state_o        debug view of the FSM state
module passcode_scramble_register #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        prog_en_i,
  input  logic [3:0]  digit_in_i,
  input  logic        digit_valid_i,
  input  logic        commit_i,
  input  logic        cancel_i,
  output logic [15:0] stored_code_o,
  output logic        code_written_o,
  output logic        entry_error_o,
  output logic        busy_o,
  output logic [2:0]  digit_count_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_COLLECT      = 3'd1,
    S_READY        = 3'd2,
    S_WRITE        = 3'd3
`ifdef CONFIRM_ENTRY_EN
    ,
    S_CONF_COLLECT = 3'd4,
    S_CONF_READY   = 3'd5
`endif
  } state_t;

  // The idle counter is 16 bits wide, so TIMEOUT_CYCLES must not exceed 65535.
  localparam logic [15:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  function automatic logic [15:0] scramble(input logic [15:0] c);
    return {c[11:8], c[7:4], c[15:12], c[3:0]};
  endfunction

  state_t      state_q;
  logic [15:0] code_buf_q;
  logic [2:0]  count_q;
  logic [15:0] tmo_q;
  logic [15:0] stored_code_q;
  logic        code_written_q;
  logic        entry_error_q;
  logic        busy_q;
`ifdef CONFIRM_ENTRY_EN
  logic [15:0] confirm_buf_q;
`endif

  // Event classification for the entry states. The priority order is:
  // abort (cancel or prog_en low), then commit, then digit.
  logic in_entry, at_full, abort_req, commit_ok, digit_ok, reject, timeout_hit;

  always_comb begin
    in_entry = (state_q == S_COLLECT) || (state_q == S_READY);
    at_full  = (state_q == S_READY);
`ifdef CONFIRM_ENTRY_EN
    in_entry = in_entry || (state_q == S_CONF_COLLECT) || (state_q == S_CONF_READY);
    at_full  = at_full || (state_q == S_CONF_READY);
`endif
    abort_req = in_entry && (!prog_en_i || cancel_i);
    commit_ok = in_entry && !abort_req && commit_i && at_full;
    digit_ok  = in_entry && !abort_req && !commit_i && digit_valid_i &&
                !at_full && (digit_in_i <= 4'd9);
    reject    = in_entry && !abort_req &&
                ((commit_i && !at_full) || (!commit_i && digit_valid_i && !digit_ok));
    // The idle counter is cleared only by accepted digits and by state
    // changes, so rejected events still count toward the timeout.
    timeout_hit = (TIMEOUT_CYCLES > 0) && in_entry && !abort_req &&
                  !commit_ok && !digit_ok && (tmo_q == TMO_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      code_buf_q     <= '0;
      count_q        <= '0;
      tmo_q          <= '0;
      stored_code_q  <= scramble(DEFAULT_CODE);
      code_written_q <= 1'b0;
      entry_error_q  <= 1'b0;
      busy_q         <= 1'b0;
`ifdef CONFIRM_ENTRY_EN
      confirm_buf_q  <= '0;
`endif
    end else begin
      code_written_q <= 1'b0;
      entry_error_q  <= reject || timeout_hit;
      busy_q         <= 1'b1;
      if (state_q == S_IDLE) begin
        busy_q <= prog_en_i;
        if (prog_en_i) begin
          state_q    <= S_COLLECT;
          count_q    <= '0;
          code_buf_q <= '0;
          tmo_q      <= '0;
        end
      end else if (state_q == S_WRITE) begin
        // The write always completes. busy_o stays high through the edge
        // that lands the code, so it falls one edge after stored_code_o
        // has settled.
        stored_code_q  <= scramble(code_buf_q);
        code_written_q <= 1'b1;
        state_q        <= S_IDLE;
        code_buf_q     <= '0;
      end else if (abort_req || timeout_hit) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        count_q    <= '0;
        code_buf_q <= '0;
        tmo_q      <= '0;
`ifdef CONFIRM_ENTRY_EN
        confirm_buf_q <= '0;
`endif
      end else if (commit_ok) begin
        count_q <= '0;
        tmo_q   <= '0;
`ifdef CONFIRM_ENTRY_EN
        if (state_q == S_READY) begin
          state_q       <= S_CONF_COLLECT;
          confirm_buf_q <= '0;
        end else if (confirm_buf_q == code_buf_q) begin
          state_q <= S_WRITE;
        end else begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          code_buf_q    <= '0;
          confirm_buf_q <= '0;
          entry_error_q <= 1'b1;
        end
`else
        state_q <= S_WRITE;
`endif
      end else if (digit_ok) begin
        count_q <= count_q + 3'd1;
        tmo_q   <= '0;
`ifdef CONFIRM_ENTRY_EN
        if (state_q == S_CONF_COLLECT) begin
          confirm_buf_q <= {confirm_buf_q[11:0], digit_in_i};
          if (count_q == 3'd3) state_q <= S_CONF_READY;
        end else begin
          code_buf_q <= {code_buf_q[11:0], digit_in_i};
          if (count_q == 3'd3) state_q <= S_READY;
        end
`else
        code_buf_q <= {code_buf_q[11:0], digit_in_i};
        if (count_q == 3'd3) state_q <= S_READY;
`endif
      end else if (TIMEOUT_CYCLES > 0) begin
        tmo_q <= tmo_q + 16'd1;
      end
    end
  end

  assign stored_code_o  = stored_code_q;
  assign code_written_o = code_written_q;
  assign entry_error_o  = entry_error_q;
  assign busy_o         = busy_q;
  assign digit_count_o  = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_passcode_scramble_register.sv
module tb_passcode_scramble_register;

  localparam logic [15:0] DEF = 16'h1234;
  localparam int          TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_en = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        digit_valid = 1'b0;
  logic        commit = 1'b0;
  logic        cancel = 1'b0;
  logic [15:0] stored_code;
  logic        code_written;
  logic        entry_error;
  logic        busy;
  logic [2:0]  digit_count;
  logic [2:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  passcode_scramble_register #(
    .DEFAULT_CODE   (DEF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .prog_en_i      (prog_en),
    .digit_in_i     (digit),
    .digit_valid_i  (digit_valid),
    .commit_i       (commit),
    .cancel_i       (cancel),
    .stored_code_o  (stored_code),
    .code_written_o (code_written),
    .entry_error_o  (entry_error),
    .busy_o         (busy),
    .digit_count_o  (digit_count),
    .state_o        (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The entry is tracked as lists of typed digits. Phases are plain flags.
  bit          m_active;
  bit          m_confirming;
  bit          m_write_pending;
  bit          m_busy;
  logic [3:0]  m_first[$];
  logic [3:0]  m_second[$];
  int          m_idle;
  logic [15:0] m_code;
  bit          e_written;
  bit          e_error;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] scr_digits(input logic [3:0] d3, d2, d1, d0);
    return {d2, d1, d3, d0};
  endfunction

  function automatic int exp_count();
    if (!m_active) return 0;
    return m_confirming ? m_second.size() : m_first.size();
  endfunction

  task automatic clear_entry();
    m_first.delete();
    m_second.delete();
    m_confirming = 0;
    m_idle = 0;
  endtask

  task automatic finish_entry();
`ifdef CONFIRM_ENTRY_EN
    bit same;
    if (!m_confirming) begin
      m_confirming = 1;
      m_second.delete();
    end else begin
      same = 1;
      for (int i = 0; i < 4; i++) if (m_first[i] != m_second[i]) same = 0;
      if (same) begin
        m_active = 0;
        m_confirming = 0;
        m_write_pending = 1;
      end else begin
        m_active = 0;
        clear_entry();
        e_error = 1;
      end
    end
`else
    m_active = 0;
    m_write_pending = 1;
`endif
  endtask

  task automatic model_step();
    bit wrote;
    bit accepted;
    int size;
    wrote = 0;
    e_written = 0;
    e_error = 0;
    if (reset) begin
      m_active = 0;
      m_write_pending = 0;
      clear_entry();
      m_code = scr_digits(DEF[15:12], DEF[11:8], DEF[7:4], DEF[3:0]);
      m_busy = 0;
      exp_q.delete();
      return;
    end
    if (m_write_pending) begin
      m_code = scr_digits(m_first[0], m_first[1], m_first[2], m_first[3]);
      exp_q.push_back(m_code);
      e_written = 1;
      wrote = 1;
      m_write_pending = 0;
      clear_entry();
    end else if (!m_active) begin
      if (prog_en) begin
        m_active = 1;
        clear_entry();
      end
    end else if (!prog_en || cancel) begin
      m_active = 0;
      clear_entry();
    end else begin
      accepted = 0;
      size = m_confirming ? m_second.size() : m_first.size();
      if (commit) begin
        if (size == 4) begin
          accepted = 1;
          finish_entry();
        end else e_error = 1;
      end else if (digit_valid) begin
        if (size < 4 && digit <= 4'd9) begin
          accepted = 1;
          if (m_confirming) m_second.push_back(digit);
          else m_first.push_back(digit);
        end else e_error = 1;
      end
      if (accepted) m_idle = 0;
      else begin
        m_idle++;
        if (TMO > 0 && m_idle >= TMO) begin
          m_active = 0;
          clear_entry();
          e_error = 1;
        end
      end
    end
    m_busy = wrote || m_active || m_write_pending;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_outputs();
    check_eq("stored_code", stored_code, m_code);
    check_eq("code_written", code_written, e_written);
    check_eq("entry_error", entry_error, e_error);
    check_eq("busy", busy, m_busy);
    check_eq("digit_count", digit_count, exp_count());
    if (code_written) begin
      check_eq("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("written_value", stored_code, exp_q.pop_front());
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit rst, input bit pe, input bit dv, input logic [3:0] d,
                       input bit cm, input bit cn);
    reset = rst;
    prog_en = pe;
    digit_valid = dv;
    digit = d;
    commit = cm;
    cancel = cn;
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic enter();           cycle(0, 1, 0, 4'd0, 0, 0); endtask
  task automatic dig(input logic [3:0] d); cycle(0, 1, 1, d, 0, 0); endtask
  task automatic cmt();             cycle(0, 1, 0, 4'd0, 1, 0); endtask
  task automatic rest(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'd0, 0, 0);
  endtask

  logic [3:0] code4[4];

  task automatic key_code(input logic [3:0] a, b, c, d);
    dig(a); dig(b); dig(c); dig(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit       r_pe, r_dv, r_cm, r_cn, r_rst;
    logic [3:0] r_d;

    cycle(1, 0, 0, 4'd0, 0, 0);
    cycle(1, 0, 0, 4'd0, 0, 0);
    check_eq("reset_stored_code", stored_code, 16'h2314);
    check_eq("reset_busy", busy, 0);
    cycle(0, 0, 0, 4'd0, 0, 0);

    // Full entry and write, with digits strobed back-to-back.
    enter();
    key_code(4'd5, 4'd6, 4'd7, 4'd8);
    cmt();
`ifdef CONFIRM_ENTRY_EN
    key_code(4'd5, 4'd6, 4'd7, 4'd8);
    cmt();
`endif
    cycle(0, 1, 0, 4'd0, 0, 0);
    check_eq("write_code", stored_code, 16'h6758);
    check_eq("write_pulse", code_written, 1);
    rest(3);

    // The code from the test plan.
    enter();
    key_code(4'd1, 4'd2, 4'd3, 4'd4);
    cmt();
`ifdef CONFIRM_ENTRY_EN
    key_code(4'd1, 4'd2, 4'd3, 4'd4);
    cmt();
`endif
    cycle(0, 0, 0, 4'd0, 0, 0);
    check_eq("write_code_1234", stored_code, 16'h2314);
    rest(2);

    // An illegal digit is rejected and does not count.
    enter();
    dig(4'd5);
    dig(4'd12);
    check_eq("illegal_digit_err", entry_error, 1);
    dig(4'd6);
    check_eq("count_after_illegal", digit_count, 2);
    cycle(0, 1, 0, 4'd0, 0, 1);
    rest(2);

    // An early commit is rejected. cancel wins over commit in the same cycle.
    enter();
    dig(4'd9);
    dig(4'd8);
    cmt();
    check_eq("early_commit_err", entry_error, 1);
    check_eq("early_commit_count", digit_count, 2);
    cycle(0, 1, 0, 4'd0, 1, 1);
    check_eq("cancel_no_error", entry_error, 0);
    rest(2);

`ifdef CONFIRM_ENTRY_EN
    // The confirmation entry does not match the first entry.
    enter();
    key_code(4'd4, 4'd3, 4'd2, 4'd1);
    cmt();
    key_code(4'd4, 4'd3, 4'd2, 4'd0);
    cmt();
    check_eq("confirm_mismatch_err", entry_error, 1);
    rest(3);
    check_eq("confirm_keeps_code", stored_code, 16'h2314);
`endif

    // Timeout: one digit followed by TMO idle cycles.
    enter();
    dig(4'd7);
    for (int i = 0; i < TMO; i++) cycle(0, 1, 0, 4'd0, 0, 0);
    check_eq("timeout_err", entry_error, 1);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_count", digit_count, 0);
    rest(2);

    // A digit that arrives in the cycle prog_en falls is discarded.
    enter();
    dig(4'd1);
    cycle(0, 0, 1, 4'd2, 0, 0);
    check_eq("prog_drop_count", digit_count, 0);
    rest(2);

    // Reset in the middle of an entry reloads the default code.
    enter();
    key_code(4'd9, 4'd9, 4'd9, 4'd9);
    cmt();
`ifdef CONFIRM_ENTRY_EN
    key_code(4'd9, 4'd9, 4'd9, 4'd9);
    cmt();
`endif
    rest(2);
    check_eq("pre_reset_code", stored_code, 16'h9999);
    enter();
    dig(4'd3);
    cycle(1, 1, 0, 4'd0, 0, 0);
    check_eq("midreset_code", stored_code, 16'h2314);
    rest(2);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int k = 0; k < 10; k++) cycle(0, 1, 0, 4'd0, 0, 0);
      end else begin
        r_rst = ($urandom_range(0, 999) < 2);
        r_pe  = ($urandom_range(0, 99) >= 3);
        r_dv  = ($urandom_range(0, 99) < 55);
        r_d   = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9))
                                             : 4'($urandom_range(10, 15));
        r_cm  = ($urandom_range(0, 99) < 10);
        r_cn  = ($urandom_range(0, 99) < 2);
        cycle(r_rst, r_pe, r_dv, r_d, r_cm, r_cn);
      end
    end
    rest(3);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
